audio_record_buffer: RTL and testbench

- Sits directly downstream of the PDM deserializer.
- Captures each completed 16-bit PDM word into on-chip block RAM while recording.
- Replays the stored words in order to the playback stage using a valid/ready handshake.
- Controlled by single-cycle record/play/stop strobes from the top-level controller; reports its state, the recorded length and a full condition.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_bram.sv | 33 +++
 rtl/audio_record_buffer.sv | 122 ++++++++++++
 tb/tb_audio_record_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio record/playback buffer and its controller.
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECORD    = 2'd1,
    PLAY_READ = 2'd2,
    PLAY_HOLD = 2'd3
  } rec_state_t;

endpackage

// File: rtl/audio_bram.sv
// Simple dual-port block RAM: one write port, one synchronous read port.
module audio_bram #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register reset maps onto the BRAM's own output-latch reset; memory is untouched.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_record_buffer.sv
// Records deserialized PDM words into block RAM and replays them over a valid/ready handshake.
module audio_record_buffer
  import audio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              record_i,
  input  logic              play_i,
  input  logic              stop_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_i,
  output logic              play_valid_o,
  output logic [DATA_W-1:0] play_data_o,
  input  logic              play_ready_i,
  output logic              recording_o,
  output logic              playing_o,
  output logic              full_o,
  output logic [ADDR_W:0]   length_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);

  rec_state_t        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   length_q;
  logic [ADDR_W:0]   rd_next;
  logic              full_q;
  logic              play_valid_q;
  logic              ram_we;
  logic              ram_re;

  assign ram_we  = (state == RECORD) && word_valid_i && !reset_i;
  assign ram_re  = (state == PLAY_READ);
  assign rd_next = {1'b0, rd_addr} + LEN_ONE;

  audio_bram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bram (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data (word_i),
    .rd_en   (ram_re),
    .rd_addr (rd_addr),
    .rd_data (play_data_o)
  );

  // A write landing on the last address ends the take even if stop_i arrives in the same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= IDLE;
      wr_addr      <= '0;
      rd_addr      <= '0;
      length_q     <= '0;
      full_q       <= 1'b0;
      play_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (record_i) begin
            state    <= RECORD;
            wr_addr  <= '0;
            full_q   <= 1'b0;
            length_q <= '0;
          end else if (play_i && (length_q != '0)) begin
            state   <= PLAY_READ;
            rd_addr <= '0;
          end
        end
        RECORD: begin
          if (word_valid_i) begin
            wr_addr  <= wr_addr + ADDR_ONE;
            length_q <= {1'b0, wr_addr} + LEN_ONE;
          end
          if (word_valid_i && (wr_addr == LAST_ADDR)) begin
            state  <= IDLE;
            full_q <= 1'b1;
          end else if (stop_i) begin
            state <= IDLE;
          end
        end
        PLAY_READ: begin
          if (stop_i) begin
            state <= IDLE;
          end else begin
            state        <= PLAY_HOLD;
            play_valid_q <= 1'b1;
          end
        end
        PLAY_HOLD: begin
          if (stop_i) begin
            state        <= IDLE;
            play_valid_q <= 1'b0;
          end else if (play_ready_i) begin
            play_valid_q <= 1'b0;
            rd_addr      <= rd_next[ADDR_W-1:0];
            state        <= (rd_next < length_q) ? PLAY_READ : IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          play_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign recording_o  = (state == RECORD);
  assign playing_o    = (state == PLAY_READ) || (state == PLAY_HOLD);
  assign play_valid_o = play_valid_q;
  assign full_o       = full_q;
  assign length_o     = length_q;

endmodule

// File: tb/tb_audio_record_buffer.sv
// Scoreboard bench for audio_record_buffer with an 8-word buffer.
module tb_audio_record_buffer;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              record_i = 1'b0;
  logic              play_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              word_valid_i = 1'b0;
  logic [DATA_W-1:0] word_i = '0;
  logic              play_ready_i = 1'b0;
  logic              play_valid_o;
  logic [DATA_W-1:0] play_data_o;
  logic              recording_o;
  logic              playing_o;
  logic              full_o;
  logic [ADDR_W:0]   length_o;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [DATA_W-1:0] exp_q [$];

  audio_record_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .record_i     (record_i),
    .play_i       (play_i),
    .stop_i       (stop_i),
    .word_valid_i (word_valid_i),
    .word_i       (word_i),
    .play_valid_o (play_valid_o),
    .play_data_o  (play_data_o),
    .play_ready_i (play_ready_i),
    .recording_o  (recording_o),
    .playing_o    (playing_o),
    .full_o       (full_o),
    .length_o     (length_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Drives one cycle of strobes, then returns all strobes to zero.
  task automatic applyStimulus(input logic rec, input logic ply, input logic stp,
                               input logic wv, input logic [DATA_W-1:0] w);
    record_i     = rec;
    play_i       = ply;
    stop_i       = stp;
    word_valid_i = wv;
    word_i       = w;
    tick();
    record_i     = 1'b0;
    play_i       = 1'b0;
    stop_i       = 1'b0;
    word_valid_i = 1'b0;
  endtask

  task automatic runPlayback(input string tag, input int n_words);
    int cyc;
    int vcount;
    cyc    = 0;
    vcount = 0;
    play_ready_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    while (playing_o && cyc < 100) begin
      if (play_valid_o) vcount++;
      cyc++;
      tick();
    end
    checkOutput({tag, "_play_cycles"}, cyc, 2 * n_words);
    checkOutput({tag, "_valid_cycles"}, vcount, n_words);
    checkOutput({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  initial begin
    logic [DATA_W-1:0] exp_word;
    forever begin
      @(negedge clock_i);
      if (play_valid_o && play_ready_i && !stop_i && !reset_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", {16'h0, play_data_o}, 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("play_word", {16'h0, play_data_o}, {16'h0, exp_word});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    tick();
    tick();
    reset_i = 1'b0;
    checkOutput("rst_recording", recording_o, 0);
    checkOutput("rst_playing", playing_o, 0);
    checkOutput("rst_valid", play_valid_o, 0);
    checkOutput("rst_length", length_o, 0);
    checkOutput("rst_full", full_o, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("play_len0_ignored", playing_o, 0);

    $display("[TB] basic record");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("rec_entered", recording_o, 1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'(i * 16'h1111));
    end
    checkOutput("rec_before_stop", recording_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("rec_after_stop", recording_o, 0);
    checkOutput("rec_length", length_o, 5);
    checkOutput("rec_full", full_o, 0);

    $display("[TB] playback order");
    for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i * 16'h1111));
    runPlayback("basic", 5);
    checkOutput("basic_playing_off", playing_o, 0);

    $display("[TB] back-pressure");
    for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i * 16'h1111));
    play_ready_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(play_valid_o === 1'b1 && play_data_o === 16'h1111)) bad++;
      tick();
    end
    checkOutput("bp_unstable_cycles", bad, 0);
    play_ready_i = 1'b1;
    for (int i = 0; i < 100 && playing_o; i++) tick();
    checkOutput("bp_sb_drained", exp_q.size(), 0);

    $display("[TB] full buffer");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'(i));
      if (i == 8) checkOutput("full_idle_after_8", recording_o, 0);
    end
    checkOutput("full_flag", full_o, 1);
    checkOutput("full_length", length_o, 8);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    runPlayback("full", 8);

    $display("[TB] simultaneous events");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("recplay_recording", recording_o, 1);
    checkOutput("recplay_playing", playing_o, 0);
    checkOutput("recplay_full_clr", full_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0A01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0A02);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);
    checkOutput("stopwv_recording", recording_o, 0);
    checkOutput("stopwv_length", length_o, 3);
    exp_q.push_back(16'h0A01);
    exp_q.push_back(16'h0A02);
    exp_q.push_back(16'hABCD);
    runPlayback("stopwv", 3);

    $display("[TB] reset mid-operation");
    play_ready_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    checkOutput("hold_valid", play_valid_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("rsthold_valid", play_valid_o, 0);
    checkOutput("rsthold_playing", playing_o, 0);
    checkOutput("rsthold_data", play_data_o, 0);
    checkOutput("rsthold_length", length_o, 0);
    checkOutput("rsthold_full", full_o, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("rsthold_play_ignored", playing_o, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h8888);
    checkOutput("rec2_length", length_o, 2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("rstrec_recording", recording_o, 0);
    checkOutput("rstrec_length", length_o, 0);
    checkOutput("rstrec_full", full_o, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("rstrec_play_ignored", playing_o, 0);

    tick();
    checkOutput("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
